// File: rtl/line_stepper.sv
// Bresenham line stepper: latches endpoints on start and emits one pixel per accepted handshake.
// Define LINE_STEPPER_COUNT_EN to add the pix_count output (accepted-pixel counter).
module line_stepper #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          done
`ifdef LINE_STEPPER_COUNT_EN
    ,
    output logic [XW:0]   pix_count
`endif
);

    // Error term is XW+2 bits for the default geometry; widened if y is the wider axis.
    localparam int unsigned EW = ((XW > YW) ? XW : YW) + 2;

    localparam logic [XW-1:0] XOne = XW'(1);
    localparam logic [YW-1:0] YOne = YW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StDraw,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [XW-1:0]         x1_q, x1_d;
    logic [YW-1:0]         y1_q, y1_d;
    logic [XW-1:0]         dx_q, dx_d;
    logic [YW-1:0]         dy_q, dy_d;
    logic                  sx_neg_q, sx_neg_d;
    logic                  sy_neg_q, sy_neg_d;
    logic signed [EW-1:0]  err_q, err_d;

    logic                  accept;
    logic                  last_pix;
    logic                  step_x;
    logic                  step_y;
    logic signed [EW:0]    e2;
    logic signed [EW:0]    dx_ext;
    logic signed [EW:0]    dy_ext;
    logic signed [EW:0]    err_ext;
    logic signed [EW:0]    err_next;
    logic [XW-1:0]         dx_setup;
    logic [YW-1:0]         dy_setup;

    assign accept   = (state_q == StDraw) && out_ready;
    assign last_pix = (x_q == x1_q) && (y_q == y1_q);

    assign dx_ext  = signed'({{(EW + 1 - XW){1'b0}}, dx_q});
    assign dy_ext  = signed'({{(EW + 1 - YW){1'b0}}, dy_q});
    assign err_ext = signed'({err_q[EW-1], err_q});
    assign e2      = signed'({err_q, 1'b0});
    assign step_x  = e2 > -dy_ext;
    assign step_y  = e2 < dx_ext;

    assign dx_setup = (x1_q < x_q) ? (x_q - x1_q) : (x1_q - x_q);
    assign dy_setup = (y1_q < y_q) ? (y_q - y1_q) : (y1_q - y_q);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        err_next = err_ext;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    x_d     = x0;
                    y_d     = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                end
            end
            StSetup: begin
                state_d  = StDraw;
                dx_d     = dx_setup;
                dy_d     = dy_setup;
                sx_neg_d = x1_q < x_q;
                sy_neg_d = y1_q < y_q;
                err_next = signed'({{(EW + 1 - XW){1'b0}}, dx_setup})
                         - signed'({{(EW + 1 - YW){1'b0}}, dy_setup});
                err_d    = err_next[EW-1:0];
            end
            StDraw: begin
                if (accept) begin
                    if (last_pix) begin
                        state_d = StDone;
                    end else begin
                        // Both axis steps may fire together; each adjusts err independently.
                        if (step_x) begin
                            err_next = err_next - dy_ext;
                            x_d      = sx_neg_q ? (x_q - XOne) : (x_q + XOne);
                        end
                        if (step_y) begin
                            err_next = err_next + dx_ext;
                            y_d      = sy_neg_q ? (y_q - YOne) : (y_q + YOne);
                        end
                        err_d = err_next[EW-1:0];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

`ifdef LINE_STEPPER_COUNT_EN
    logic [XW:0] pix_count_q, pix_count_d;

    always_comb begin
        pix_count_d = pix_count_q;
        if ((state_q == StIdle) && start) begin
            pix_count_d = '0;
        end else if (accept) begin
            pix_count_d = pix_count_q + (XW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_count_q <= '0;
        end else begin
            pix_count_q <= pix_count_d;
        end
    end

    assign pix_count = pix_count_q;
`endif

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDraw);
    assign done      = (state_q == StDone);
    assign x         = x_q;
    assign y         = y_q;

    // A stalled pixel must not move.
    assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> ($stable(x_q) && $stable(y_q) && $stable(err_q)));

endmodule
